// File: rtl/exe_ctrl_pkg.sv
// Shared types and opcodes for the execute-stage sequencer.
// Imported by exe_ctrl, its multiplier and the bench.
package exe_ctrl_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 64;

  localparam logic [7:0] INST_ADD = 8'h01;
  localparam logic [7:0] INST_MUL = 8'h02;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } exe_state_t;

  typedef struct packed {
    logic [4:0] rd_addr;
    logic [4:0] inst_type;
  } exe_tag_t;

  function automatic logic is_mul_op(
    input logic [7:0] op,
    input bit         en
  );
    return en && (op == INST_MUL);
  endfunction

endpackage

// File: rtl/exe_ctrl_if.sv
// Decode-side and writeback-side handshake bundle of exe_ctrl.
// master drives ops and wb_ready; slave is the execute stage.
interface exe_ctrl_if #(
  parameter int unsigned DW = 64
) ();

  logic          flush;
  logic          id_valid;
  logic          id_ready;
  logic [7:0]    inst_opcode;
  logic [4:0]    inst_type_i;
  logic [4:0]    rd_addr_i;
  logic [DW-1:0] op1;
  logic [DW-1:0] op2;
  logic          ex_valid;
  logic          wb_ready;
  logic [DW-1:0] rd_data;
  logic [4:0]    rd_addr_o;
  logic [4:0]    inst_type_o;
  logic          busy;

  modport master (
    output flush,
    output id_valid,
    output inst_opcode,
    output inst_type_i,
    output rd_addr_i,
    output op1,
    output op2,
    output wb_ready,
    input  id_ready,
    input  ex_valid,
    input  rd_data,
    input  rd_addr_o,
    input  inst_type_o,
    input  busy
  );

  modport slave (
    input  flush,
    input  id_valid,
    input  inst_opcode,
    input  inst_type_i,
    input  rd_addr_i,
    input  op1,
    input  op2,
    input  wb_ready,
    output id_ready,
    output ex_valid,
    output rd_data,
    output rd_addr_o,
    output inst_type_o,
    output busy
  );

endinterface

// File: rtl/exe_mul_iter.sv
// Iterative shift-add multiplier, one partial product per cycle.
// done_o/product_o are combinational on the last step.
module exe_mul_iter
  import exe_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  kill_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] op1_i,
  input  logic [DATA_WIDTH-1:0] op2_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] product_o
);

  localparam int unsigned CW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic                  run_q, run_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [DATA_WIDTH-1:0] acc_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  // Final step is folded into product_o so the result lands on the done edge.
  assign acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign done_o    = run_q && (cnt_q == LAST);
  assign product_o = acc_step;

  always_comb begin
    run_d    = run_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (kill_i) begin
      run_d = 1'b0;
    end else if (start_i) begin
      run_d    = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = op1_i;
      mplier_d = op2_i;
    end else if (run_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (done_o) run_d = 1'b0;
    end
  end

endmodule

// File: rtl/exe_ctrl.sv
// Execute-stage sequencer: single-cycle ADD/unknown, iterative MUL,
// result held in S_DONE until writeback takes it.
module exe_ctrl
  import exe_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter bit          MUL_EN     = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  exe_ctrl_if.slave bus
);

  exe_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  exe_tag_t              tag_q, tag_d;

  logic                  id_ready;
  logic                  ex_valid;
  logic                  accept;
  logic                  transfer;
  logic                  op_mul;
  logic                  op_add;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  mul_done;
  logic [DATA_WIDTH-1:0] mul_prod;

  assign op_mul = is_mul_op(bus.inst_opcode, MUL_EN);
  assign op_add = (bus.inst_opcode == INST_ADD);

  assign ex_valid = (state_q == S_DONE);
  assign id_ready = !bus.flush &&
                    ((state_q == S_IDLE) ||
                     ((state_q == S_DONE) && bus.wb_ready));
  assign accept   = bus.id_valid && id_ready;
  assign transfer = ex_valid && bus.wb_ready;

  always_comb begin
    unique case (1'b1)
      op_add:  alu_res = bus.op1 + bus.op2;
      default: alu_res = '0;
    endcase
  end

  exe_mul_iter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .kill_i   (bus.flush),
    .start_i  (accept && op_mul),
    .op1_i    (bus.op1),
    .op2_i    (bus.op2),
    .done_o   (mul_done),
    .product_o(mul_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    tag_d   = tag_q;

    if (accept) begin
      tag_d = '{rd_addr: bus.rd_addr_i,
                inst_type: bus.inst_type_i};
    end

    if (accept && !op_mul) begin
      data_d = alu_res;
    end else if ((state_q == S_MUL) && mul_done) begin
      data_d = mul_prod;
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = op_mul ? S_MUL : S_DONE;
      end
      S_MUL: begin
        if (mul_done) state_d = S_DONE;
      end
      S_DONE: begin
        // Back-to-back accept on transfer keeps the pipe bubble-free.
        if (transfer) begin
          if (accept) state_d = op_mul ? S_MUL : S_DONE;
          else        state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.flush) state_d = S_IDLE;
  end

  assign bus.id_ready    = id_ready;
  assign bus.ex_valid    = ex_valid;
  assign bus.rd_data     = data_q;
  assign bus.rd_addr_o   = tag_q.rd_addr;
  assign bus.inst_type_o = tag_q.inst_type;
  assign bus.busy        = (state_q == S_MUL);

endmodule

// File: tb/tb_exe_ctrl.sv
// Self-checking bench for exe_ctrl: transaction-level model,
// per-cycle compare, directed scenarios with literal expectations.
module tb_exe_ctrl;
  import exe_ctrl_pkg::*;

  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exe_ctrl_if #(.DW(DW)) bus ();
  exe_ctrl_if #(.DW(DW)) bus0 ();

  exe_ctrl #(.DATA_WIDTH(DW), .MUL_EN(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exe_ctrl #(.DATA_WIDTH(DW), .MUL_EN(1'b0)) dut0 (
    .clk(clk),
    .rst(rst),
    .bus(bus0)
  );

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int busy_cnt = 0;
  logic [63:0] got_d[$];
  int          got_c[$];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Transaction-level model: pending result, multiply countdown.
  bit          m_valid, m_busy;
  int          m_left;
  logic [63:0] m_data, m_mres;
  logic [4:0]  m_rd, m_ty;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_valid = 0; m_busy = 0; m_left = 0;
        m_data = '0; m_rd = '0; m_ty = '0; m_mres = '0;
      end else begin : upd
        bit rdy, acc, xfer;
        rdy  = !bus.flush && !m_busy && (!m_valid || bus.wb_ready);
        acc  = bus.id_valid && rdy;
        xfer = m_valid && bus.wb_ready;
        if (bus.flush) begin
          m_valid = 0;
          m_busy  = 0;
        end else begin
          if (xfer) m_valid = 0;
          if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
              m_busy  = 0;
              m_valid = 1;
              m_data  = m_mres;
            end
          end
          if (acc) begin
            m_rd = bus.rd_addr_i;
            m_ty = bus.inst_type_i;
            if (bus.inst_opcode == INST_MUL) begin
              m_busy = 1;
              m_left = DW;
              m_mres = bus.op1 * bus.op2;
            end else begin
              m_valid = 1;
              m_data  = (bus.inst_opcode == INST_ADD) ?
                        bus.op1 + bus.op2 : 64'd0;
            end
          end
        end
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      cyc_n++;
      if (rst) begin
        chk("rst_ex_valid", 64'(bus.ex_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_rd_data", bus.rd_data, 64'd0);
        chk("rst_rd_addr", 64'(bus.rd_addr_o), 64'd0);
        chk("rst_type", 64'(bus.inst_type_o), 64'd0);
      end else begin : cmp
        bit rdy;
        rdy = !bus.flush && !m_busy && (!m_valid || bus.wb_ready);
        chk("id_ready", 64'(bus.id_ready), 64'(rdy));
        chk("ex_valid", 64'(bus.ex_valid), 64'(m_valid));
        chk("busy", 64'(bus.busy), 64'(m_busy));
        if (m_valid) begin
          chk("rd_data", bus.rd_data, m_data);
          chk("rd_addr_o", 64'(bus.rd_addr_o), 64'(m_rd));
          chk("inst_type_o", 64'(bus.inst_type_o), 64'(m_ty));
        end
        if (bus.ex_valid && bus.wb_ready) begin
          got_d.push_back(bus.rd_data);
          got_c.push_back(cyc_n);
        end
        if (bus.busy) busy_cnt++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] op, input logic [63:0] a,
                      input logic [63:0] b, input logic [4:0] rd,
                      input logic [4:0] ty, output int acc_c);
    bus.id_valid    = 1'b1;
    bus.inst_opcode = op;
    bus.op1         = a;
    bus.op2         = b;
    bus.rd_addr_i   = rd;
    bus.inst_type_i = ty;
    acc_c = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (bus.id_ready) begin
        acc_c = cyc_n;
        break;
      end
    end
    if (acc_c < 0) chk("accept_timeout", 64'd0, 64'd1);
    cyc();
    bus.id_valid = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget);
    for (int i = 0; i < budget && got_d.size() < n; i++) cyc();
    chk("xfer_count", 64'(got_d.size()), 64'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin : main
    int ac, n0, b0;
    bus.flush = 0; bus.id_valid = 0; bus.inst_opcode = '0;
    bus.op1 = '0; bus.op2 = '0; bus.rd_addr_i = '0;
    bus.inst_type_i = '0; bus.wb_ready = 0;
    bus0.flush = 0; bus0.id_valid = 0; bus0.inst_opcode = '0;
    bus0.op1 = '0; bus0.op2 = '0; bus0.rd_addr_i = '0;
    bus0.inst_type_i = '0; bus0.wb_ready = 1;

    repeat (3) @(posedge clk);
    #2 rst = 0;
    @(negedge clk); #1;
    chk("reset_id_ready", 64'(bus.id_ready), 64'd1);
    chk("reset_ex_valid", 64'(bus.ex_valid), 64'd0);
    cyc();

    // ADD stream, throughput one per cycle
    bus.wb_ready = 1;
    n0 = got_d.size();
    send(INST_ADD, 64'd1, 64'd2, 5'd1, 5'd1, ac);
    send(INST_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd2, 5'd1, ac);
    send(INST_ADD, 64'd5, 64'd7, 5'd3, 5'd1, ac);
    wait_got(n0 + 3, 10);
    if (got_d.size() >= n0 + 3) begin
      chk("add_1p2", got_d[n0], 64'd3);
      chk("add_wrap", got_d[n0+1], 64'd0);
      chk("add_5p7", got_d[n0+2], 64'd12);
      chk("add_b2b_1", 64'(got_c[n0+1] - got_c[n0]), 64'd1);
      chk("add_b2b_2", 64'(got_c[n0+2] - got_c[n0]), 64'd2);
    end

    // MUL latency and truncation
    n0 = got_d.size();
    b0 = busy_cnt;
    send(INST_MUL, 64'd6, 64'd7, 5'd4, 5'd5, ac);
    wait_got(n0 + 1, 100);
    if (got_d.size() >= n0 + 1) begin
      chk("mul_6x7", got_d[n0], 64'd42);
      chk("mul_latency", 64'(got_c[n0] - ac), 64'd65);
    end
    chk("mul_busy_cycles", 64'(busy_cnt - b0), 64'd64);
    n0 = got_d.size();
    send(INST_MUL, 64'h1_0000_0000, 64'h1_0000_0000, 5'd5, 5'd5, ac);
    wait_got(n0 + 1, 100);
    if (got_d.size() >= n0 + 1) chk("mul_trunc", got_d[n0], 64'd0);

    // Backpressure
    bus.wb_ready = 0;
    n0 = got_d.size();
    send(INST_ADD, 64'd10, 64'd20, 5'd7, 5'd2, ac);
    repeat (5) begin
      @(negedge clk); #1;
      chk("bp_valid", 64'(bus.ex_valid), 64'd1);
      chk("bp_data", bus.rd_data, 64'd30);
      chk("bp_rd", 64'(bus.rd_addr_o), 64'd7);
      chk("bp_ready", 64'(bus.id_ready), 64'd0);
    end
    cyc();
    bus.wb_ready = 1;
    cyc();
    @(negedge clk); #1;
    chk("bp_drop", 64'(bus.ex_valid), 64'd0);
    chk("bp_count", 64'(got_d.size()), 64'(n0 + 1));
    cyc();

    // Flush mid-MUL with a pending op
    n0 = got_d.size();
    send(INST_MUL, 64'd123, 64'd456, 5'd9, 5'd3, ac);
    repeat (19) @(posedge clk);
    #2;
    bus.flush = 1; bus.id_valid = 1; bus.inst_opcode = INST_ADD;
    bus.op1 = 64'd100; bus.op2 = 64'd1; bus.rd_addr_i = 5'd10;
    @(negedge clk); #1;
    chk("flush_ready", 64'(bus.id_ready), 64'd0);
    cyc();
    bus.flush = 0;
    @(negedge clk); #1;
    chk("flush_ex", 64'(bus.ex_valid), 64'd0);
    chk("flush_busy", 64'(bus.busy), 64'd0);
    chk("flush_accept", 64'(bus.id_ready), 64'd1);
    cyc();
    bus.id_valid = 0;
    repeat (70) cyc();
    chk("flush_count", 64'(got_d.size()), 64'(n0 + 1));
    if (got_d.size() >= n0 + 1) chk("flush_next", got_d[n0], 64'd101);

    // Reset mid-MUL
    n0 = got_d.size();
    send(INST_MUL, 64'd3, 64'd5, 5'd13, 5'd4, ac);
    repeat (10) cyc();
    rst = 1;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_data", bus.rd_data, 64'd0);
    chk("arst_rd", 64'(bus.rd_addr_o), 64'd0);
    chk("arst_type", 64'(bus.inst_type_o), 64'd0);
    cyc();
    rst = 0;
    @(negedge clk); #1;
    chk("arst_ready", 64'(bus.id_ready), 64'd1);
    repeat (70) cyc();
    chk("arst_noresult", 64'(got_d.size()), 64'(n0));

    // Unknown opcode
    n0 = got_d.size();
    send(8'hFF, 64'd9, 64'd9, 5'd1, 5'd6, ac);
    wait_got(n0 + 1, 10);
    if (got_d.size() >= n0 + 1) begin
      chk("unk_data", got_d[n0], 64'd0);
      chk("unk_latency", 64'(got_c[n0] - ac), 64'd1);
    end

    // MUL disabled build treats MUL as unknown
    bus0.id_valid = 1; bus0.inst_opcode = INST_MUL;
    bus0.op1 = 64'd3; bus0.op2 = 64'd3; bus0.rd_addr_i = 5'd6;
    @(negedge clk); #1;
    chk("m0_ready", 64'(bus0.id_ready), 64'd1);
    cyc();
    bus0.id_valid = 0;
    @(negedge clk); #1;
    chk("m0_valid", 64'(bus0.ex_valid), 64'd1);
    chk("m0_data", bus0.rd_data, 64'd0);
    chk("m0_busy", 64'(bus0.busy), 64'd0);
    chk("m0_rd", 64'(bus0.rd_addr_o), 64'd6);

    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
